// File: rtl/fifo_param.sv
// -----------------------------------------------------------------------------
// fifo_param
//
// Parametrised single-clock FIFO between a producer and a consumer. The depth
// is a power of two. The read data output is registered. Each request type has
// a registered ack/err pair that reports the previous cycle's request.
//
// Parameters:
//   DATA_WIDTH  width of din/dout
//   ADDR_WIDTH  pointer width; DEPTH = 2**ADDR_WIDTH
//   AF_LEVEL    almost_full  when data_count >= AF_LEVEL
//   AE_LEVEL    almost_empty when data_count <= AE_LEVEL
//
// Ports:
//   clk            rising-edge clock for all state
//   reset_n        synchronous active-low reset
//   wr_en, din     write request and its data
//   rd_en          read request
//   dout           registered read data (0 in any cycle without an accepted read)
//   data_count     stored entries, 0..DEPTH
//   full, empty    count == DEPTH / count == 0
//   almost_full    count >= AF_LEVEL
//   almost_empty   count <= AE_LEVEL
//   wr_ack/wr_err  registered result of the previous cycle's write request
//   rd_ack/rd_err  registered result of the previous cycle's read request
// -----------------------------------------------------------------------------
module fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] head_q,  head_d;
  logic [ADDR_WIDTH-1:0] tail_q,  tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q,  dout_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  wr_err_q, wr_err_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  rd_err_q, rd_err_d;

  logic                  full_w;
  logic                  empty_w;
  logic                  rd_accept;
  logic                  wr_accept;

  // ---------------------------------------------------------------------------
  // Flags decode straight from the count register, so they track the count
  // after the most recent edge with no extra cycle of lag.
  // ---------------------------------------------------------------------------
  assign full_w  = (count_q == DEPTH_CNT);
  assign empty_w = (count_q == '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first. A path that skips an
    // assignment would otherwise infer a latch.
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    dout_d   = '0;
    wr_ack_d = 1'b0;
    wr_err_d = 1'b0;
    rd_ack_d = 1'b0;
    rd_err_d = 1'b0;

    // There is no bypass. A read of an empty FIFO is rejected even when a
    // write arrives in the same cycle.
    rd_accept = rd_en && !empty_w;

    // At full, a write is still taken when a read frees a slot in the same
    // cycle. The new word lands in that slot, since tail == head when full.
    wr_accept = wr_en && (!full_w || rd_accept);

    if (rd_accept) begin
      dout_d = mem_q[head_q];
      head_d = head_q + ADDR_WIDTH'(1);   // wraps modulo DEPTH
    end

    if (wr_accept) begin
      tail_d = tail_q + ADDR_WIDTH'(1);   // wraps modulo DEPTH
    end

    count_d = count_q + CW'(wr_accept) - CW'(rd_accept);

    wr_ack_d = wr_accept;
    wr_err_d = wr_en && !wr_accept;
    rd_ack_d = rd_accept;
    rd_err_d = rd_en && !rd_accept;
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // see the values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset. After reset the pointers make every entry
  // unreachable until it is rewritten, so clearing it would only cost logic.
  // A write in a reset cycle is ignored, so memory is left untouched too.
  always_ff @(posedge clk) begin
    if (reset_n && wr_accept) begin
      mem_q[tail_q] <= din;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dout         = dout_q;
  assign data_count   = count_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign wr_ack       = wr_ack_q;
  assign wr_err       = wr_err_q;
  assign rd_ack       = rd_ack_q;
  assign rd_err       = rd_err_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_count_bounded : assert property (@(posedge clk) disable iff (!reset_n)
    count_q <= DEPTH_CNT);

  a_ptr_gap : assert property (@(posedge clk) disable iff (!reset_n)
    (tail_q - head_q) == count_q[ADDR_WIDTH-1:0]);

  a_ack_err_exclusive : assert property (@(posedge clk)
    !(wr_ack_q && wr_err_q) && !(rd_ack_q && rd_err_q));

endmodule

// File: tb/tb_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_param
//
// Bench for fifo_param. One instance uses the default parameters. The second
// uses DATA_WIDTH=8, ADDR_WIDTH=4, AF_LEVEL=12 and AE_LEVEL=3. A reference
// count and a data queue predict the status, flags, count and read data after
// each clock edge.
// -----------------------------------------------------------------------------
module tb_fifo_param;

  logic        clk = 1'b0;
  logic        reset_n;

  // default instance: 8 x 32
  logic        wr_en, rd_en;
  logic [31:0] din, dout;
  logic [3:0]  data_count;
  logic        full, empty, almost_full, almost_empty;
  logic        wr_ack, wr_err, rd_ack, rd_err;

  // second instance: 16 x 8, AF=12, AE=3
  logic        b_wr_en, b_rd_en;
  logic [7:0]  b_din, b_dout;
  logic [4:0]  b_count;
  logic        b_full, b_empty, b_af, b_ae;
  logic        b_wr_ack, b_wr_err, b_rd_ack, b_rd_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] sb_a [$];
  logic [7:0]  sb_b [$];
  int          cnt_a = 0;
  int          cnt_b = 0;

  always #5 clk = ~clk;

  fifo_param dut_a (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
    .data_count(data_count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
  );

  fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .wr_en(b_wr_en), .din(b_din), .rd_en(b_rd_en), .dout(b_dout),
    .data_count(b_count), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae),
    .wr_ack(b_wr_ack), .wr_err(b_wr_err), .rd_ack(b_rd_ack), .rd_err(b_rd_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle on the default instance. The reference model predicts the
  // outcome, then the outputs are sampled 1 time unit after the edge.
  task automatic step_a(input logic w, input logic [31:0] d, input logic r);
    bit          ra, wa;
    logic [31:0] exp_d;
    wr_en = w; din = d; rd_en = r;
    ra    = r && (cnt_a != 0);
    wa    = w && (cnt_a < 8 || ra);
    exp_d = '0;
    if (ra) exp_d = sb_a.pop_front();
    if (wa) sb_a.push_back(d);
    cnt_a = cnt_a + int'(wa) - int'(ra);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check("a.wr_ack", {31'd0, wr_ack}, {31'd0, wa});
    check("a.wr_err", {31'd0, wr_err}, {31'd0, w && !wa});
    check("a.rd_ack", {31'd0, rd_ack}, {31'd0, ra});
    check("a.rd_err", {31'd0, rd_err}, {31'd0, r && !ra});
    check("a.dout", dout, exp_d);
    check("a.count", {28'd0, data_count}, 32'(cnt_a));
    check("a.full", {31'd0, full}, {31'd0, cnt_a == 8});
    check("a.empty", {31'd0, empty}, {31'd0, cnt_a == 0});
    check("a.almost_full", {31'd0, almost_full}, {31'd0, cnt_a >= 7});
    check("a.almost_empty", {31'd0, almost_empty}, {31'd0, cnt_a <= 1});
  endtask

  task automatic step_b(input logic w, input logic [7:0] d, input logic r);
    bit         ra, wa;
    logic [7:0] exp_d;
    b_wr_en = w; b_din = d; b_rd_en = r;
    ra    = r && (cnt_b != 0);
    wa    = w && (cnt_b < 16 || ra);
    exp_d = '0;
    if (ra) exp_d = sb_b.pop_front();
    if (wa) sb_b.push_back(d);
    cnt_b = cnt_b + int'(wa) - int'(ra);
    @(posedge clk); #1;
    b_wr_en = 1'b0; b_rd_en = 1'b0;
    check("b.wr_ack", {31'd0, b_wr_ack}, {31'd0, wa});
    check("b.wr_err", {31'd0, b_wr_err}, {31'd0, w && !wa});
    check("b.rd_ack", {31'd0, b_rd_ack}, {31'd0, ra});
    check("b.dout", {24'd0, b_dout}, {24'd0, exp_d});
    check("b.count", {27'd0, b_count}, 32'(cnt_b));
    check("b.full", {31'd0, b_full}, {31'd0, cnt_b == 16});
    check("b.empty", {31'd0, b_empty}, {31'd0, cnt_b == 0});
    check("b.almost_full", {31'd0, b_af}, {31'd0, cnt_b >= 12});
    check("b.almost_empty", {31'd0, b_ae}, {31'd0, cnt_b <= 3});
  endtask

  // Reset for one cycle with both requests raised on the default instance.
  // Those requests must be ignored and must produce no status.
  task automatic do_reset();
    reset_n = 1'b0;
    wr_en = 1'b1; rd_en = 1'b1; din = 32'hEEEE_EEEE;
    b_wr_en = 1'b0; b_rd_en = 1'b0; b_din = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0;
    sb_a.delete(); sb_b.delete();
    cnt_a = 0; cnt_b = 0;
    check("rst.count", {28'd0, data_count}, 32'd0);
    check("rst.empty", {31'd0, empty}, 32'd1);
    check("rst.full", {31'd0, full}, 32'd0);
    check("rst.almost_full", {31'd0, almost_full}, 32'd0);
    check("rst.almost_empty", {31'd0, almost_empty}, 32'd1);
    check("rst.dout", dout, 32'd0);
    check("rst.status", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'd0);
    check("rst.b_count", {27'd0, b_count}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; din = '0;
    b_wr_en = 1'b0; b_rd_en = 1'b0; b_din = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Fill with 0x11..0x88, then one write too many.
    for (int i = 1; i <= 8; i++) step_a(1'b1, 32'(i * 32'h11), 1'b0);
    step_a(1'b1, 32'h99, 1'b0);

    // Drain in order, then one read too many.
    for (int i = 0; i < 8; i++) step_a(1'b0, '0, 1'b1);
    step_a(1'b0, '0, 1'b1);

    // Empty with both requests: no bypass. The word is read on the next cycle.
    step_a(1'b1, 32'hA5, 1'b1);
    step_a(1'b0, '0, 1'b1);

    // Full with both requests for 3 cycles, then drain across the wrap.
    for (int i = 0; i < 8; i++) step_a(1'b1, 32'h20 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) step_a(1'b1, 32'hC1 + 32'(i), 1'b1);
    for (int i = 0; i < 8; i++) step_a(1'b0, '0, 1'b1);

    // Reset mid-operation with 5 entries stored, then a fresh write/read pair.
    for (int i = 0; i < 5; i++) step_a(1'b1, 32'h30 + 32'(i), 1'b0);
    do_reset();
    step_a(1'b1, 32'h5A5A_0001, 1'b0);
    step_a(1'b0, '0, 1'b1);

    // Mixed random traffic.
    for (int i = 0; i < 400; i++)
      step_a(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

    // Second instance: walk the thresholds up to full and back down.
    for (int i = 0; i < 16; i++) step_b(1'b1, 8'(8'h40 + i), 1'b0);
    step_b(1'b1, 8'hFF, 1'b0);
    step_b(1'b1, 8'h77, 1'b1);
    for (int i = 0; i < 17; i++) step_b(1'b0, '0, 1'b1);
    for (int i = 0; i < 200; i++)
      step_b(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
